// File: rtl/rc_approx_mon_pkg.sv
// Shared types and width helpers for the approximate-adder error monitor.
// Contents: FSM state enum, default operand/counter widths, and derived-width
// functions for the signed error, squared error and accumulator.
package rc_approx_mon_pkg;

  localparam int unsigned DefWidth = 16;
  localparam int unsigned DefCntW  = 16;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Signed error: exact and approx are both WIDTH+1 bits, difference needs one more.
  function automatic int unsigned err_w(int unsigned width);
    return width + 2;
  endfunction

  function automatic int unsigned sq_w(int unsigned width);
    return 2 * (width + 1);
  endfunction

  // Up to 2^cnt_w-1 squared terms never overflow this width.
  function automatic int unsigned acc_w(int unsigned width, int unsigned cnt_w);
    return sq_w(width) + cnt_w;
  endfunction

endpackage

// File: rtl/rc_approx_err_monitor_if.sv
// Sample/command/result bundle of the error monitor.
// master: the characterisation harness (drives start, samples, res_ready).
// slave : the monitor (drives in_ready, res_valid, statistics, busy).
interface rc_approx_err_monitor_if #(
  parameter int unsigned WIDTH = rc_approx_mon_pkg::DefWidth,
  parameter int unsigned CNT_W = rc_approx_mon_pkg::DefCntW
);
  import rc_approx_mon_pkg::*;

  logic                             start;
  logic [CNT_W-1:0]                 n_samples;
  logic                             in_valid;
  logic                             in_ready;
  logic [WIDTH-1:0]                 IN1;
  logic [WIDTH-1:0]                 IN2;
  logic [WIDTH:0]                   approx_sum;
  logic                             res_valid;
  logic                             res_ready;
  logic [acc_w(WIDTH, CNT_W)-1:0]   sq_err_sum;
  logic [WIDTH:0]                   max_abs_err;
  logic [CNT_W-1:0]                 mismatch_cnt;
  logic                             busy;

  modport master (
    output start, n_samples, in_valid, IN1, IN2, approx_sum, res_ready,
    input  in_ready, res_valid, sq_err_sum, max_abs_err, mismatch_cnt, busy
  );

  modport slave (
    input  start, n_samples, in_valid, IN1, IN2, approx_sum, res_ready,
    output in_ready, res_valid, sq_err_sum, max_abs_err, mismatch_cnt, busy
  );

endinterface

// File: rtl/rc_err_stage.sv
// Combinational error datapath for one sample.
// in1_i, in2_i : operands
// approx_i     : approximate sum under test (WIDTH+1 bits)
// err_o        : exact - approx, signed
// abs_err_o    : |err_o|
// sq_err_o     : err_o squared
module rc_err_stage
  import rc_approx_mon_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
) (
  input  logic [WIDTH-1:0]                in1_i,
  input  logic [WIDTH-1:0]                in2_i,
  input  logic [WIDTH:0]                  approx_i,
  output logic signed [err_w(WIDTH)-1:0]  err_o,
  output logic [WIDTH:0]                  abs_err_o,
  output logic [sq_w(WIDTH)-1:0]          sq_err_o
);

  localparam int unsigned ErrW = err_w(WIDTH);
  localparam int unsigned SqW  = sq_w(WIDTH);

  logic [WIDTH:0]          exact;
  logic signed [ErrW-1:0]  neg_err;
  logic [SqW-1:0]          abs_ext;

  always_comb begin
    exact     = {1'b0, in1_i} + {1'b0, in2_i};
    err_o     = $signed({1'b0, exact}) - $signed({1'b0, approx_i});
    neg_err   = -err_o;
    // Magnitude is at most 2^(WIDTH+1)-1, so the low WIDTH+1 bits are exact.
    abs_err_o = err_o[ErrW-1] ? neg_err[WIDTH:0] : err_o[WIDTH:0];
    abs_ext   = {{(SqW - WIDTH - 1){1'b0}}, abs_err_o};
    sq_err_o  = abs_ext * abs_ext;
  end

endmodule

// File: rtl/rc_approx_err_monitor.sv
// Error-statistics monitor for approximate ripple-carry adders.
// clk, rst_n : clock, asynchronous active-low reset
// bus        : slave side of rc_approx_err_monitor_if (start/n_samples command,
//              valid/ready sample stream, held result with res_valid/res_ready,
//              sq_err_sum, max_abs_err, mismatch_cnt, busy)
// Two-stage pipeline: S1 registers the error terms of an accepted sample,
// S2 folds them into the batch statistics.
module rc_approx_err_monitor
  import rc_approx_mon_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned CNT_W = DefCntW
) (
  input logic                    clk,
  input logic                    rst_n,
  rc_approx_err_monitor_if.slave bus
);

  localparam int unsigned ErrW = err_w(WIDTH);
  localparam int unsigned SqW  = sq_w(WIDTH);
  localparam int unsigned AccW = acc_w(WIDTH, CNT_W);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       n_q, n_d;
  logic [CNT_W-1:0]       acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0]       done_cnt_q, done_cnt_d;
  logic [CNT_W-1:0]       mism_q, mism_d;
  logic                   s1_valid_q, s1_valid_d;
  logic signed [ErrW-1:0] s1_err_q, s1_err_d;
  logic [WIDTH:0]         s1_abs_q, s1_abs_d;
  logic [SqW-1:0]         s1_sq_q, s1_sq_d;
  logic [AccW-1:0]        sq_sum_q, sq_sum_d;
  logic [WIDTH:0]         max_q, max_d;
  logic                   res_valid_q, res_valid_d;
  logic                   busy_q, busy_d;

  logic                   in_ready;
  logic                   accept;
  logic signed [ErrW-1:0] stage_err;
  logic [WIDTH:0]         stage_abs;
  logic [SqW-1:0]         stage_sq;

  rc_err_stage #(
    .WIDTH (WIDTH)
  ) u_err_stage (
    .in1_i     (bus.IN1),
    .in2_i     (bus.IN2),
    .approx_i  (bus.approx_sum),
    .err_o     (stage_err),
    .abs_err_o (stage_abs),
    .sq_err_o  (stage_sq)
  );

  // Ready falls as soon as the accept count reaches the batch length.
  assign in_ready = (state_q == StRun) && (acc_cnt_q < n_q);
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    acc_cnt_d  = acc_cnt_q;
    done_cnt_d = done_cnt_q;
    mism_d     = mism_q;
    sq_sum_d   = sq_sum_q;
    max_d      = max_q;
    s1_valid_d = accept;
    s1_err_d   = s1_err_q;
    s1_abs_d   = s1_abs_q;
    s1_sq_d    = s1_sq_q;

    // S1
    if (accept) begin
      acc_cnt_d = acc_cnt_q + CNT_W'(1);
      s1_err_d  = stage_err;
      s1_abs_d  = stage_abs;
      s1_sq_d   = stage_sq;
    end

    // S2
    if (s1_valid_q) begin
      sq_sum_d   = sq_sum_q + AccW'(s1_sq_q);
      done_cnt_d = done_cnt_q + CNT_W'(1);
      if (s1_abs_q > max_q) max_d = s1_abs_q;
      if (s1_err_q != '0) mism_d = mism_q + CNT_W'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          n_d        = bus.n_samples;
          acc_cnt_d  = '0;
          done_cnt_d = '0;
          mism_d     = '0;
          sq_sum_d   = '0;
          max_d      = '0;
          state_d    = (bus.n_samples == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if ((done_cnt_q == n_q) && !s1_valid_q) state_d = StDone;
      end
      StDone: begin
        if (bus.res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    res_valid_d = (state_d == StDone);
    busy_d      = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      n_q         <= '0;
      acc_cnt_q   <= '0;
      done_cnt_q  <= '0;
      mism_q      <= '0;
      s1_valid_q  <= 1'b0;
      s1_err_q    <= '0;
      s1_abs_q    <= '0;
      s1_sq_q     <= '0;
      sq_sum_q    <= '0;
      max_q       <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      acc_cnt_q   <= acc_cnt_d;
      done_cnt_q  <= done_cnt_d;
      mism_q      <= mism_d;
      s1_valid_q  <= s1_valid_d;
      s1_err_q    <= s1_err_d;
      s1_abs_q    <= s1_abs_d;
      s1_sq_q     <= s1_sq_d;
      sq_sum_q    <= sq_sum_d;
      max_q       <= max_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.res_valid    = res_valid_q;
  assign bus.busy         = busy_q;
  assign bus.sq_err_sum   = sq_sum_q;
  assign bus.max_abs_err  = max_q;
  assign bus.mismatch_cnt = mism_q;

endmodule

// File: tb/tb_rc_approx_err_monitor.sv
module tb_rc_approx_err_monitor;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  int   cyc;
  int   accepts;
  longint unsigned wc_sq;

  rc_approx_err_monitor_if #(.WIDTH(16), .CNT_W(16)) bus ();

  rc_approx_err_monitor #(
    .WIDTH (16),
    .CNT_W (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic check_results(input string tag, input logic [63:0] sq, input logic [63:0] mx,
                               input logic [63:0] mm);
    check({tag, "_res_valid"}, 64'(bus.res_valid), 64'd1);
    check({tag, "_sq"}, 64'(bus.sq_err_sum), sq);
    check({tag, "_max"}, 64'(bus.max_abs_err), mx);
    check({tag, "_mism"}, 64'(bus.mismatch_cnt), mm);
  endtask

  task automatic set_sample(input logic [15:0] a, input logic [15:0] b, input logic [16:0] s);
    bus.IN1        = a;
    bus.IN2        = b;
    bus.approx_sum = s;
  endtask

  task automatic start_batch(input logic [15:0] n);
    bus.start     = 1'b1;
    bus.n_samples = n;
    tick();
    bus.start = 1'b0;
  endtask

  // Call right after the edge that accepted the last sample; cnt = cycles to res_valid.
  task automatic wait_res(output int cnt);
    cnt = 1;
    while (!bus.res_valid && cnt < 20) begin
      tick();
      cnt++;
    end
  endtask

  task automatic release_result();
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.n_samples = '0;
    bus.in_valid = 1'b0;
    bus.res_ready = 1'b0;
    set_sample(16'h0, 16'h0, 17'h0);
    tick();
    tick();

    // Reset state
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_res_valid", 64'(bus.res_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_sq", 64'(bus.sq_err_sum), 64'd0);
    check("rst_max", 64'(bus.max_abs_err), 64'd0);
    check("rst_mism", 64'(bus.mismatch_cnt), 64'd0);
    rst_n = 1'b1;
    tick();

    // One sample, err = 1024 - 1535 = -511
    start_batch(16'd1);
    check("t1_busy", 64'(bus.busy), 64'd1);
    check("t1_in_ready", 64'(bus.in_ready), 64'd1);
    set_sample(16'h0200, 16'h0200, 17'h05FF);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("t1_in_ready_after", 64'(bus.in_ready), 64'd0);
    wait_res(cyc);
    check("t1_latency", 64'(cyc), 64'd3);
    check_results("t1", 64'd261121, 64'd511, 64'd1);
    release_result();
    check("t1_idle_res_valid", 64'(bus.res_valid), 64'd0);
    check("t1_idle_busy", 64'(bus.busy), 64'd0);
    check("t1_hold_sq", 64'(bus.sq_err_sum), 64'd261121);

    // Two back-to-back samples: err +1 then 0
    start_batch(16'd2);
    bus.in_valid = 1'b1;
    set_sample(16'h01FF, 16'h0001, 17'h01FF);
    tick();
    set_sample(16'h1234, 16'h0000, 17'h1234);
    tick();
    bus.in_valid = 1'b0;
    wait_res(cyc);
    check("t2_latency", 64'(cyc), 64'd3);
    check_results("t2", 64'd1, 64'd1, 64'd1);
    release_result();

    // in_valid held for 10 cycles with n=3; each accepted err = 32 - 29 = +3
    start_batch(16'd3);
    set_sample(16'h0010, 16'h0010, 17'h001D);
    bus.in_valid = 1'b1;
    accepts = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.in_ready) accepts++;
      tick();
    end
    bus.in_valid = 1'b0;
    check("t3_accepts", 64'(accepts), 64'd3);
    check("t3_in_ready_low", 64'(bus.in_ready), 64'd0);
    for (int i = 0; i < 5; i++) begin
      check_results("t3_hold", 64'd27, 64'd3, 64'd3);
      tick();
    end
    release_result();
    check("t3_idle_busy", 64'(bus.busy), 64'd0);

    // Empty batch goes straight to DONE with cleared results
    start_batch(16'd0);
    check_results("t4_zero", 64'd0, 64'd0, 64'd0);
    release_result();
    check("t4_idle_busy", 64'(bus.busy), 64'd0);

    // start during RUN is ignored: batch length stays 2
    start_batch(16'd2);
    set_sample(16'h0010, 16'h0010, 17'h001D);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.start = 1'b1;
    bus.n_samples = 16'd5;
    tick();
    bus.start = 1'b0;
    check("t5_busy", 64'(bus.busy), 64'd1);
    check("t5_in_ready", 64'(bus.in_ready), 64'd1);
    set_sample(16'h0010, 16'h0010, 17'h0020);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("t5_in_ready_low", 64'(bus.in_ready), 64'd0);
    wait_res(cyc);
    check("t5_latency", 64'(cyc), 64'd3);
    check_results("t5", 64'd9, 64'd3, 64'd1);
    release_result();

    // Worst case: 65535 samples of err = 131070
    wc_sq = 64'd65535 * 64'd131070 * 64'd131070;
    start_batch(16'hFFFF);
    set_sample(16'hFFFF, 16'hFFFF, 17'h0);
    bus.in_valid = 1'b1;
    cyc = 0;
    while (!bus.res_valid && cyc < 70000) begin
      tick();
      cyc++;
    end
    bus.in_valid = 1'b0;
    check_results("t6_wc", wc_sq, 64'd131070, 64'd65535);
    check("t6_in_ready_low", 64'(bus.in_ready), 64'd0);
    release_result();

    // Asynchronous reset mid-batch after two accepts
    start_batch(16'd4);
    set_sample(16'h0010, 16'h0010, 17'h001D);
    bus.in_valid = 1'b1;
    tick();
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    check("t7_pre_mism", 64'(bus.mismatch_cnt), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_rst_sq", 64'(bus.sq_err_sum), 64'd0);
    check("t7_rst_max", 64'(bus.max_abs_err), 64'd0);
    check("t7_rst_mism", 64'(bus.mismatch_cnt), 64'd0);
    check("t7_rst_busy", 64'(bus.busy), 64'd0);
    check("t7_rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("t7_rst_res_valid", 64'(bus.res_valid), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    start_batch(16'd1);
    set_sample(16'h0200, 16'h0200, 17'h05FF);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    wait_res(cyc);
    check("t7_latency", 64'(cyc), 64'd3);
    check_results("t7_clean", 64'd261121, 64'd511, 64'd1);
    release_result();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
